instruction_fetch_stage: RTL and testbench

- Holds the program counter and the IF/ID pipeline register.
- Fetches one instruction per cycle from the combinational instruction ROM and presents its OP and funct fields to the control unit.
- Consumes the control unit's Jump, JAL, JRControl, BranchEQ and BranchNE outputs to redirect fetch.
- Also handles hazard stalls, bubble insertion on redirects, and a taken-redirect counter.

---
 rtl/instruction_fetch_stage.sv | 90 +++++++++
 tb/tb_instruction_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the redirect
// logic driven by the control-unit outputs of the instruction currently in ID.
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic                  stall,
  input  logic                  Jump,
  input  logic                  JAL,
  input  logic                  JRControl,
  input  logic                  BranchEQ,
  input  logic                  BranchNE,
  input  logic                  Zero,
  input  logic [DATA_WIDTH-1:0] rs_data,
  output logic [5:0]            OP,
  output logic [5:0]            funct,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc_plus4,
  output logic                  id_valid,
  output logic [15:0]           flush_count,
  output logic                  misalign_err
);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] target;
  logic                  redirect;
  logic                  branch_taken;

  assign instr_addr = pc;
  assign pc_plus4   = pc + DATA_WIDTH'(4);
  assign OP         = id_instr[31:26];
  assign funct      = id_instr[5:0];

  assign jump_target   = {id_pc_plus4[DATA_WIDTH-1:28], id_instr[25:0], 2'b00};
  assign branch_target = id_pc_plus4
                       + {{(DATA_WIDTH-18){id_instr[15]}}, id_instr[15:0], 2'b00};
  assign branch_taken  = (BranchEQ & Zero) | (BranchNE & ~Zero);

  // Bubbles are gated by id_valid, so a NOP's decode can never redirect.
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (id_valid) begin
      if (JRControl) begin
        redirect = 1'b1;
        target   = rs_data;
      end else if (Jump || JAL) begin
        redirect = 1'b1;
        target   = jump_target;
      end else if (branch_taken) begin
        redirect = 1'b1;
        target   = branch_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      id_instr     <= '0;
      id_pc_plus4  <= '0;
      id_valid     <= 1'b0;
      flush_count  <= '0;
      misalign_err <= 1'b0;
    end else if (stall) begin
      // rs_data/Zero may be stale while stalled, so redirects wait for release.
      pc           <= pc;
    end else if (redirect) begin
      pc           <= {target[DATA_WIDTH-1:2], 2'b00};
      id_instr     <= '0;
      id_pc_plus4  <= '0;
      id_valid     <= 1'b0;
      if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      if (target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else begin
      pc           <= pc_plus4;
      id_instr     <= instr_rdata;
      id_pc_plus4  <= pc_plus4;
      id_valid     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a small ROM model feeds instr_rdata,
// and the control-unit outputs are driven by hand for the instruction in ID.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        stall, Jump, JAL, JRControl, BranchEQ, BranchNE, Zero;
  logic [31:0] rs_data;
  logic [5:0]  OP, funct;
  logic [31:0] id_instr, id_pc_plus4;
  logic        id_valid;
  logic [15:0] flush_count;
  logic        misalign_err;

  int tests  = 0;
  int failed = 0;

  instruction_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .stall(stall), .Jump(Jump), .JAL(JAL), .JRControl(JRControl),
    .BranchEQ(BranchEQ), .BranchNE(BranchNE), .Zero(Zero), .rs_data(rs_data),
    .OP(OP), .funct(funct), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .flush_count(flush_count), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // J 0x00400040 at RESET_PC, BEQ imm=3 at +8, BNE imm=-2 at +0x18, filler elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr)
      32'h0040_0000: rom = 32'h0810_0010;
      32'h0040_0008: rom = 32'h1000_0003;
      32'h0040_0018: rom = 32'h1400_FFFE;
      default:       rom = 32'hAC00_0000 | {16'h0, addr[15:0]};
    endcase
  endfunction

  assign instr_rdata = rom(instr_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; Jump = 0; JAL = 0; JRControl = 0;
    BranchEQ = 0; BranchNE = 0; Zero = 0; rs_data = 32'h0;
  endtask

  // Pulse reset between edges (entered at edge+1, released at edge+3).
  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    clear_ctrl();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_addr",     instr_addr,   32'h0040_0000);
    check("rst_valid",    id_valid,     1'b0);
    check("rst_flush",    flush_count,  16'd0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_instr",    id_instr,     32'h0);
    step();
    check("rst_hold_addr", instr_addr, 32'h0040_0000);
    #2 reset = 1'b1;
    #1;
    check("rel_addr0", instr_addr, 32'h0040_0000);

    step();
    check("seq_addr1",  instr_addr,  32'h0040_0004);
    check("seq_instr0", id_instr,    32'h0810_0010);
    check("seq_valid0", id_valid,    1'b1);
    check("seq_pc4_0",  id_pc_plus4, 32'h0040_0004);
    check("seq_op0",    OP,          6'h02);
    check("seq_funct0", funct,       6'h10);
    step();
    check("seq_addr2",  instr_addr, 32'h0040_0008);
    check("seq_instr1", id_instr,   32'hAC00_0004);
    step();
    check("seq_addr3",  instr_addr, 32'h0040_000C);
    check("seq_instr2", id_instr,   32'h1000_0003);
    check("beq_op",     OP,         6'h04);

    BranchNE = 1; Zero = 1;
    step();
    check("bne_nt_addr",  instr_addr,  32'h0040_0010);
    check("bne_nt_valid", id_valid,    1'b1);
    check("bne_nt_instr", id_instr,    32'hAC00_000C);
    check("bne_nt_flush", flush_count, 16'd0);
    clear_ctrl();

    do_reset();
    check("rst2_addr", instr_addr, 32'h0040_0000);
    step(); step(); step();
    check("beq_in_id", id_instr, 32'h1000_0003);
    BranchEQ = 1; Zero = 1;
    step();
    check("beq_addr",   instr_addr,  32'h0040_0018);
    check("beq_bubble", id_valid,    1'b0);
    check("beq_binstr", id_instr,    32'h0);
    check("beq_bop",    OP,          6'h00);
    check("beq_flush",  flush_count, 16'd1);
    clear_ctrl();
    step();
    check("tgt_addr",  instr_addr,  32'h0040_001C);
    check("tgt_instr", id_instr,    32'h1400_FFFE);
    check("tgt_valid", id_valid,    1'b1);
    check("tgt_pc4",   id_pc_plus4, 32'h0040_001C);
    BranchNE = 1; Zero = 0;
    step();
    check("bneg_addr",  instr_addr,  32'h0040_0014);
    check("bneg_flush", flush_count, 16'd2);
    check("bneg_valid", id_valid,    1'b0);
    clear_ctrl();

    do_reset();
    step();
    Jump = 1;
    step();
    check("j_addr",  instr_addr,  32'h0040_0040);
    check("j_valid", id_valid,    1'b0);
    check("j_flush", flush_count, 16'd1);
    clear_ctrl();
    step();
    check("j_next_addr",  instr_addr,  32'h0040_0044);
    check("j_next_instr", id_instr,    32'hAC00_0040);
    check("j_next_pc4",   id_pc_plus4, 32'h0040_0044);

    do_reset();
    step();
    JAL = 1;
    check("jal_link", id_pc_plus4, 32'h0040_0004);
    check("jal_op",   OP,          6'h02);
    step();
    check("jal_addr", instr_addr, 32'h0040_0040);
    JAL = 0;
    step();
    check("pre_jr_valid", id_valid, 1'b1);
    JRControl = 1; Jump = 1; rs_data = 32'h0040_0103;
    step();
    check("jr_addr",     instr_addr,   32'h0040_0100);
    check("jr_misalign", misalign_err, 1'b1);
    check("jr_flush",    flush_count,  16'd2);
    clear_ctrl();
    step();
    check("jr_next_addr", instr_addr,   32'h0040_0104);
    check("jr_sticky1",   misalign_err, 1'b1);
    step();
    check("jr_sticky2",   misalign_err, 1'b1);

    do_reset();
    check("rst_misalign_clr", misalign_err, 1'b0);
    step(); step(); step();
    stall = 1; BranchEQ = 1; Zero = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_addr%0d", i),  instr_addr,  32'h0040_000C);
      check($sformatf("stall_instr%0d", i), id_instr,    32'h1000_0003);
      check($sformatf("stall_flush%0d", i), flush_count, 16'd0);
    end
    stall = 0;
    step();
    check("unstall_addr",  instr_addr,  32'h0040_0018);
    check("unstall_flush", flush_count, 16'd1);
    check("unstall_valid", id_valid,    1'b0);
    clear_ctrl();

    do_reset();
    step();
    Jump = 1;
    step();
    Jump = 0;
    step();
    check("mid_pre_flush", flush_count, 16'd1);
    check("mid_pre_valid", id_valid,    1'b1);
    JRControl = 1; rs_data = 32'h0040_0200;
    #2 reset = 1'b0;
    #1;
    check("mid_addr",  instr_addr,  32'h0040_0000);
    check("mid_valid", id_valid,    1'b0);
    check("mid_flush", flush_count, 16'd0);
    check("mid_instr", id_instr,    32'h0);
    step();
    check("mid_hold_addr", instr_addr, 32'h0040_0000);
    clear_ctrl();
    reset = 1'b1;
    step();
    check("resume_addr",  instr_addr, 32'h0040_0004);
    check("resume_instr", id_instr,   32'h0810_0010);
    check("resume_valid", id_valid,   1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
